// File: rtl/interval_timer.sv
// Interval timer: counts tick rising edges down from a loaded duration.
// Supports one-shot/auto-reload modes, pause, abort, and sticky expiry/overrun flags.
module interval_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [WIDTH-1:0] duration,
    input  logic             periodic,
    input  logic             pause,
    input  logic             stop,
    input  logic             ack,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    state_t           state;
    logic             tick_q;
    logic [WIDTH-1:0] dur_q;
    logic             per_q;

    logic rise;
    logic zero_start;
    logic expire_tick;
    logic fire;

    assign rise        = tick & ~tick_q;
    assign zero_start  = start && (duration == '0);
    assign expire_tick = (state == RUN) && !pause && rise && (remaining == WIDTH'(1));

    // An expiry happens either on the last counted rise or on a zero-length start;
    // stop outranks both, and a start shadows any rise in the same cycle.
    assign fire = !stop && (start ? zero_start : expire_tick);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            expired   <= 1'b0;
            overrun   <= 1'b0;
            dur_q     <= '0;
            per_q     <= 1'b0;
            tick_q    <= 1'b1;
        end else begin
            tick_q <= tick;
            done   <= fire;

            // Setting the flags takes precedence over the ack that would clear them.
            if (fire) begin
                expired <= 1'b1;
            end else if (ack) begin
                expired <= 1'b0;
            end

            if (fire && expired && !ack) begin
                overrun <= 1'b1;
            end else if (ack) begin
                overrun <= 1'b0;
            end

            if (stop) begin
                if (state != IDLE) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                end
            end else if (start) begin
                dur_q <= duration;
                per_q <= periodic;
                if (zero_start) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                end else begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    remaining <= duration;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (pause) begin
                            state <= PAUSED;
                        end else if (rise) begin
                            if (remaining > WIDTH'(1)) begin
                                remaining <= remaining - WIDTH'(1);
                            end else if (per_q) begin
                                remaining <= dur_q;
                            end else begin
                                remaining <= '0;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end
                        end
                    end
                    PAUSED: begin
                        if (!pause) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the duration and remaining-count values.
REQ-002 clk  input  1  system clock; the only clock in the block.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tick  input  1  time-base square wave from the clock divider, synchronous to clk; each 0->1 transition is one time unit.
REQ-005 start  input  1  one-cycle request to load duration and periodic, then begin counting.
REQ-006 duration  input  WIDTH  interval length in time units, sampled only when start is accepted.
REQ-007 periodic  input  1  mode sampled with start: 1 = auto-reload, 0 = one-shot.
REQ-008 pause  input  1  level; freezes counting while high.
REQ-009 stop  input  1  one-cycle abort request.
REQ-010 ack  input  1  one-cycle clear of expired and overrun.
REQ-011 remaining  output  WIDTH  time units left in the current interval.
REQ-012 busy  output  1  high in states RUN and PAUSED.
REQ-013 done  output  1  one-cycle pulse on each expiry.
REQ-014 expired  output  1  sticky expiry flag.
REQ-015 overrun  output  1  sticky flag: an expiry occurred while expired was already set.

Function
REQ-016 The block SHALL register tick into tick_q every cycle and define rise = tick AND NOT tick_q; only rise advances the count.
REQ-017 The state machine SHALL have exactly three states: IDLE, RUN and PAUSED.
REQ-018 The block SHALL register duration and periodic into internal dur_q and per_q on every accepted start.
REQ-019 Command priority SHALL be stop > start > pause > rise.
REQ-020 Stop in RUN or PAUSED SHALL go to IDLE next cycle with remaining=0 and no done; stop in IDLE SHALL have no effect.
REQ-021 Stop asserted together with start SHALL cause start to be ignored.
REQ-022 Start with duration>0 in any state SHALL load remaining=duration and enter RUN next cycle.
REQ-023 Start in RUN or PAUSED SHALL restart the interval, and a rise in that same cycle SHALL be ignored.
REQ-024 Start with duration=0 SHALL go to IDLE with remaining=0 and SHALL assert done on the next cycle, setting expired and applying the overrun rule.
REQ-025 In RUN with pause=1, the block SHALL enter PAUSED next cycle, and a rise in that cycle SHALL be ignored.
REQ-026 In PAUSED, rises SHALL be ignored, remaining SHALL hold, and pause=0 SHALL return the block to RUN next cycle.
REQ-027 In RUN, a rise with remaining>1 SHALL decrement remaining by 1.
REQ-028 In RUN, a rise with remaining==1 SHALL be an expiry: done=1 for exactly the next cycle and expired set.
REQ-029 On a periodic expiry (per_q=1), remaining SHALL reload to dur_q and the block SHALL stay in RUN with no lost rise.
REQ-030 On a one-shot expiry (per_q=0), remaining SHALL become 0 and the block SHALL go to IDLE.
REQ-031 Latency from the detected expiry rise to done SHALL be exactly 1 clk.
REQ-032 On expiry with expired already 1 and ack=0, the block SHALL set overrun.
REQ-033 Ack SHALL clear both expired and overrun; if a set condition occurs in the same cycle as ack, set SHALL win.
REQ-034 Decrement SHALL never wrap below 0, and remaining=0 SHALL never occur in RUN.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While rst=1, the block SHALL force state=IDLE, remaining=0, busy=0, done=0, expired=0, overrun=0, dur_q=0, per_q=0 and tick_q=1, so no spurious rise occurs at reset release.
REQ-037 Reset asserted mid-interval SHALL abort the interval on the next clk edge with no done pulse.
REQ-038 Reset SHALL override every other input.

Verification
REQ-039 The bench SHALL cover, with tick rising every 8 clk: start, duration=3, periodic=0 -> remaining 3,2,1,0 on successive rises; done pulse of 1 cycle after the 3rd rise; expired=1; busy=0.
REQ-040 The bench SHALL cover: start, duration=2, periodic=1, 5 rises -> done after rises 2 and 4; remaining sequence 2,1,2,1,2,1; overrun=1 after rise 4 with no ack.
REQ-041 The bench SHALL cover: duration=4, pause high for 3 rises after the 1st rise -> remaining holds 3; done only after 3 further rises following pause release.
REQ-042 The bench SHALL cover: stop and start in the same cycle during RUN with remaining=2 -> IDLE, remaining=0, no done; a later start with duration=0 -> done next cycle, expired=1.
REQ-043 The bench SHALL cover: ack in the same cycle as an expiry -> expired stays 1; ack alone on the following cycle -> expired=0 and overrun=0.
REQ-044 The bench SHALL cover: rst pulsed mid-interval with tick held at 1 -> all outputs 0; no count change on the first cycle after reset release.
